// File: rtl/fetch_pkg.sv
// Shared constants and queue-entry layout for the instruction fetch queue.
package fetch_pkg;

  localparam int INSTR_BYTES = 4;
  localparam int FETCH_XLEN  = 32;

  // Canonical entry layout; the fetch path packs {instr, npc} in this order.
  typedef struct packed {
    logic [FETCH_XLEN-1:0] instr;
    logic [FETCH_XLEN-1:0] npc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with power-of-2 depth, occupancy count and synchronous flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             full;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count gates validity, so stale words are never observed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: PC register, redirect mux and a decoupling queue toward decode.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IMEM_AW  = 7,
  parameter int              QDEPTH   = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      redirect_valid,
  input  logic [XLEN-1:0]           redirect_pc,
  output logic [IMEM_AW-1:0]        imem_addr,
  input  logic [XLEN-1:0]           imem_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [XLEN-1:0]           out_instr,
  output logic [XLEN-1:0]           out_npc,
  output logic [$clog2(QDEPTH):0]   q_count
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int EW = 2 * XLEN;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_inc;
  logic            pop;
  logic            fetch_en;
  logic            push;
  logic            q_empty;
  logic [EW-1:0]   head;
  logic            unused_low_bits;

  assign pc_inc    = pc + XLEN'(INSTR_BYTES);
  assign imem_addr = pc[IMEM_AW+1:2];
  assign pop       = out_valid & out_ready;
  assign fetch_en  = (q_count < CW'(QDEPTH)) | pop;
  assign unused_low_bits = ^redirect_pc[1:0];

  // NOTE: every output of a combinational block gets a default first, or a latch is inferred.
  always_comb begin
    pc_next = pc;
    push    = 1'b0;
    if (redirect_valid) begin
      pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (fetch_en) begin
      pc_next = pc_inc;
      push    = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  // A redirect flushes the queue; any pop in that cycle is absorbed by the flush.
  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (reset),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata ({imem_data, pc_inc}),
    .rdata (head),
    .count (q_count),
    .empty (q_empty)
  );

  assign out_valid = ~q_empty;
  assign out_instr = out_valid ? head[EW-1:XLEN] : '0;
  assign out_npc   = out_valid ? head[XLEN-1:0]  : '0;

endmodule
